// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch channel: one request/response pair between the
// fetch unit (master) and the instruction memory (slave).
interface pc_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch sequencer with
// branch redirect, misaligned-target trap and flush-with-kill handling.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            pc_plus4_i,
  input  logic [31:0]            br_target_i,
  input  logic                   br_take_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [31:0]            flush_pc_i,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            pc_o,
  output logic                   instr_valid,
  output logic [31:0]            instr,
  output logic                   misalign_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_TRAP = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic        misalign_q, misalign_d;

  logic [31:0] flush_pc_aligned;
  assign flush_pc_aligned = flush_pc_i & ~32'h0000_0003;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    misalign_d    = 1'b0;

    // Flush wins over everything except the post-reset IDLE cycle.
    if (flush_i && state_q != S_IDLE) begin
      pc_d          = flush_pc_aligned;
      instr_valid_d = 1'b0;
      instr_d       = NOP_INSTR;
    end

    case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (imem.imem_req_ready) begin
          state_d = S_WAIT;
          if (flush_i) kill_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (flush_i) begin
          if (imem.imem_rsp_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem.imem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d       = imem.imem_rsp_data;
            instr_valid_d = 1'b1;
            state_d       = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        if (flush_i) begin
          state_d = S_REQ;
        end else if (!stall_i) begin
          instr_valid_d = 1'b0;
          instr_d       = NOP_INSTR;
          if (!br_take_i) begin
            pc_d    = pc_plus4_i;
            state_d = S_REQ;
          end else if (br_target_i[1:0] == 2'b00) begin
            pc_d    = br_target_i;
            state_d = S_REQ;
          end else begin
            misalign_d = 1'b1;
            state_d    = S_TRAP;
          end
        end
      end

      S_TRAP: if (flush_i) state_d = S_REQ;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem.imem_req_valid = (state_q == S_REQ);
  assign imem.imem_addr      = pc_q;
  assign pc_o                = pc_q;
  assign instr_valid         = instr_valid_q;
  assign instr               = instr_q;
  assign misalign_o          = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetch, stall, branch, misalign trap,
// flush/kill interactions, reset mid-fetch and PC wrap.
module tb_pc_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_plus4_i, br_target_i, flush_pc_i;
  logic        br_take_i, stall_i, flush_i;
  logic [31:0] pc_o, instr;
  logic        instr_valid, misalign_o;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_unit_if bus();

  pc_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_plus4_i  (pc_plus4_i),
    .br_target_i (br_target_i),
    .br_take_i   (br_take_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .flush_pc_i  (flush_pc_i),
    .imem        (bus),
    .pc_o        (pc_o),
    .instr_valid (instr_valid),
    .instr       (instr),
    .misalign_o  (misalign_o)
  );

  always #5 clk = ~clk;

  // Models the external PC+4 adder fed from pc_o.
  assign pc_plus4_i = pc_o + 32'd4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From REQ: one-cycle grant, response the next cycle; ends in EXEC.
  task automatic fetch(input logic [31:0] data);
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    step();
    bus.imem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    br_target_i = '0; br_take_i = 1'b0; stall_i = 1'b0;
    flush_i = 1'b0; flush_pc_i = '0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    step(); step();
    check("rst_pc", pc_o, 32'h0);
    check("rst_iv", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr, NOP);
    check("rst_mis", {31'b0, misalign_o}, 32'h0);
    check("rst_reqv", {31'b0, bus.imem_req_valid}, 32'h0);

    rst_n = 1'b1;
    step();  // IDLE -> REQ
    check("req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    check("req_addr", bus.imem_addr, 32'h0);
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    check("wait_noreq", {31'b0, bus.imem_req_valid}, 32'h0);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0050_0093;
    step();
    bus.imem_rsp_valid = 1'b0;
    check("exec_iv", {31'b0, instr_valid}, 32'h1);
    check("exec_instr", instr, 32'h0050_0093);
    check("exec_pc", pc_o, 32'h0);
    step();
    check("seq_pc", pc_o, 32'h4);
    check("seq_addr", bus.imem_addr, 32'h4);
    check("seq_iv", {31'b0, instr_valid}, 32'h0);
    check("seq_instr", instr, NOP);

    // Stall held three cycles in EXEC.
    fetch(32'h00a0_0113);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr", instr, 32'h00a0_0113);
      check("stall_pc", pc_o, 32'h4);
      check("stall_iv", {31'b0, instr_valid}, 32'h1);
      check("stall_noreq", {31'b0, bus.imem_req_valid}, 32'h0);
    end
    stall_i = 1'b0;

    // Aligned taken branch.
    br_take_i = 1'b1; br_target_i = 32'h0000_0100;
    step();
    br_take_i = 1'b0;
    check("br_addr", bus.imem_addr, 32'h0000_0100);
    check("br_reqv", {31'b0, bus.imem_req_valid}, 32'h1);
    check("br_iv", {31'b0, instr_valid}, 32'h0);

    // Misaligned taken branch -> trap.
    fetch(32'h1111_1111);
    br_take_i = 1'b1; br_target_i = 32'h0000_0102;
    step();
    br_take_i = 1'b0;
    check("mis_pulse", {31'b0, misalign_o}, 32'h1);
    check("mis_pc", pc_o, 32'h0000_0100);
    check("mis_noreq", {31'b0, bus.imem_req_valid}, 32'h0);
    check("mis_iv", {31'b0, instr_valid}, 32'h0);
    step();
    check("mis_end", {31'b0, misalign_o}, 32'h0);
    check("trap_noreq", {31'b0, bus.imem_req_valid}, 32'h0);
    step();
    check("trap_hold", {31'b0, bus.imem_req_valid}, 32'h0);
    flush_i = 1'b1; flush_pc_i = 32'h0000_0204;
    step();
    flush_i = 1'b0;
    check("trap_flush_reqv", {31'b0, bus.imem_req_valid}, 32'h1);
    check("trap_flush_addr", bus.imem_addr, 32'h0000_0204);

    // Flush in WAIT, response two cycles later is dropped.
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    flush_i = 1'b1; flush_pc_i = 32'h0000_0203;
    step();
    flush_i = 1'b0;
    check("wflush_pc", pc_o, 32'h0000_0200);
    check("wflush_noreq", {31'b0, bus.imem_req_valid}, 32'h0);
    step();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hbad0_0001;
    step();
    bus.imem_rsp_valid = 1'b0;
    check("kill_iv", {31'b0, instr_valid}, 32'h0);
    check("kill_instr", instr, NOP);
    check("kill_reqv", {31'b0, bus.imem_req_valid}, 32'h1);
    check("kill_addr", bus.imem_addr, 32'h0000_0200);

    // Flush and response in the same WAIT cycle.
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    flush_i = 1'b1; flush_pc_i = 32'h0000_0300;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hbad0_0002;
    step();
    flush_i = 1'b0; bus.imem_rsp_valid = 1'b0;
    check("same_iv", {31'b0, instr_valid}, 32'h0);
    check("same_reqv", {31'b0, bus.imem_req_valid}, 32'h1);
    check("same_addr", bus.imem_addr, 32'h0000_0300);

    // Flush in REQ while granted: in-flight fetch is killed.
    bus.imem_req_ready = 1'b1; flush_i = 1'b1; flush_pc_i = 32'h0000_0400;
    step();
    bus.imem_req_ready = 1'b0; flush_i = 1'b0;
    check("rflush_noreq", {31'b0, bus.imem_req_valid}, 32'h0);
    check("rflush_pc", pc_o, 32'h0000_0400);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hbad0_0003;
    step();
    bus.imem_rsp_valid = 1'b0;
    check("rkill_iv", {31'b0, instr_valid}, 32'h0);
    check("rkill_reqv", {31'b0, bus.imem_req_valid}, 32'h1);
    fetch(32'hdead_beef);
    check("refetch_instr", instr, 32'hdead_beef);
    check("refetch_iv", {31'b0, instr_valid}, 32'h1);
    step();
    check("refetch_next", pc_o, 32'h0000_0404);

    // Reset mid-WAIT; late response after reset is ignored.
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("wrst_pc", pc_o, 32'h0);
    check("wrst_iv", {31'b0, instr_valid}, 32'h0);
    check("wrst_instr", instr, NOP);
    check("wrst_reqv", {31'b0, bus.imem_req_valid}, 32'h0);
    check("wrst_mis", {31'b0, misalign_o}, 32'h0);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hbad0_0004;
    step();
    bus.imem_rsp_valid = 1'b0;
    check("late_iv", {31'b0, instr_valid}, 32'h0);
    check("late_reqv", {31'b0, bus.imem_req_valid}, 32'h1);
    check("late_addr", bus.imem_addr, 32'h0);

    // PC wrap at the top of the address space.
    fetch(32'h0000_0013);
    flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFFC;
    step();
    flush_i = 1'b0;
    check("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    fetch(32'h0010_0093);
    step();
    check("wrap_pc", pc_o, 32'h0);
    check("wrap_mis", {31'b0, misalign_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
